// File: rtl/presc_updown_cnt.sv
// presc_updown_cnt: prescaled up/down modulo counter with load, tick and terminal-count pulses.
// Define PRESC_CNT_SAT_EN to saturate at the limits instead of wrapping.
module presc_updown_cnt #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] OMAX = WIDTH'(MODULUS - 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] out_q, out_d, nxt;
  logic tick_q, tick_d, tc_q, tc_d;
  logic step, at_lim;
  always_comb begin
    step   = en && pcnt_q == PMAX;
    at_lim = up ? out_q == OMAX : out_q == '0;
`ifdef PRESC_CNT_SAT_EN
    nxt    = at_lim ? out_q : up ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
`else
    nxt    = up ? (at_lim ? '0 : out_q + WIDTH'(1)) : (at_lim ? OMAX : out_q - WIDTH'(1));
`endif
    pcnt_d = load ? '0 : en ? (pcnt_q == PMAX ? '0 : pcnt_q + PW'(1)) : pcnt_q;
    out_d  = load ? (load_val > OMAX ? OMAX : load_val) : step ? nxt : out_q;
    tick_d = !load && step;
    tc_d   = !load && step && at_lim;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
      out_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end
  assign out  = out_q;
  assign tick = tick_q;
  assign tc   = tc_q;
endmodule

// File: tb/tb_presc_updown_cnt.sv
// tb_presc_updown_cnt: directed vector bench, WIDTH=4 MODULUS=10 PRESCALE=3 plus a PRESCALE=1 instance.
// Expected values follow the build (PRESC_CNT_SAT_EN selects saturating limits).
module tb_presc_updown_cnt;
`ifdef PRESC_CNT_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [3:0] WRAP_UP = 4'd9, WRAP_DN = 4'd0;
`else
  localparam bit SAT = 1'b0;
  localparam logic [3:0] WRAP_UP = 4'd0, WRAP_DN = 4'd9;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] out, out1;
  logic tick, tc, tick1, tc1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  presc_updown_cnt #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out), .tick(tick), .tc(tc));

  presc_updown_cnt #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out1), .tick(tick1), .tc(tc1));

  typedef struct {
    logic r, e, u, l;
    logic [3:0] lv, xo;
    logic xt, xc;
  } vec_t;
  vec_t tbl[29];

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, x);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] lv);
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string nm, input logic [3:0] xo, input logic xt, input logic xc);
    chk({nm, " out"}, 16'(out), 16'(xo));
    chk({nm, " tick"}, 16'(tick), 16'(xt));
    chk({nm, " tc"}, 16'(tc), 16'(xc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1,1,1,0,4'd0,  4'd0, 0,0};
    tbl[1]  = '{1,1,1,0,4'd0,  4'd0, 0,0};
    tbl[2]  = '{1,1,1,0,4'd0,  4'd1, 1,0};
    tbl[3]  = '{1,1,0,0,4'd0,  4'd1, 0,0};
    tbl[4]  = '{1,1,0,0,4'd0,  4'd1, 0,0};
    tbl[5]  = '{1,1,1,0,4'd0,  4'd2, 1,0};
    tbl[6]  = '{1,1,1,0,4'd0,  4'd2, 0,0};
    tbl[7]  = '{1,0,1,0,4'd0,  4'd2, 0,0};
    tbl[8]  = '{1,0,1,0,4'd0,  4'd2, 0,0};
    tbl[9]  = '{1,0,0,0,4'd0,  4'd2, 0,0};
    tbl[10] = '{1,0,1,0,4'd0,  4'd2, 0,0};
    tbl[11] = '{1,0,1,0,4'd0,  4'd2, 0,0};
    tbl[12] = '{1,1,1,0,4'd0,  4'd2, 0,0};
    tbl[13] = '{1,1,1,0,4'd0,  4'd3, 1,0};
    tbl[14] = '{1,0,1,1,4'd12, 4'd9, 0,0};
    tbl[15] = '{1,1,1,0,4'd0,  4'd9, 0,0};
    tbl[16] = '{1,1,1,0,4'd0,  4'd9, 0,0};
    tbl[17] = '{1,1,1,0,4'd0,  WRAP_UP, 1,1};
    tbl[18] = '{1,1,1,1,4'd4,  4'd4, 0,0};
    tbl[19] = '{1,1,0,0,4'd0,  4'd4, 0,0};
    tbl[20] = '{1,1,0,0,4'd0,  4'd4, 0,0};
    tbl[21] = '{1,1,0,0,4'd0,  4'd3, 1,0};
    tbl[22] = '{1,1,0,0,4'd0,  4'd3, 0,0};
    tbl[23] = '{1,1,0,0,4'd0,  4'd3, 0,0};
    tbl[24] = '{1,1,0,1,4'd0,  4'd0, 0,0};
    tbl[25] = '{1,1,0,0,4'd0,  4'd0, 0,0};
    tbl[26] = '{1,1,0,0,4'd0,  4'd0, 0,0};
    tbl[27] = '{1,1,0,0,4'd0,  WRAP_DN, 1,1};
    tbl[28] = '{1,1,0,0,4'd0,  WRAP_DN, 0,0};

    #1 rst = 1'b0;
    #1 chk3("reset", 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
      chk3($sformatf("vec%0d", i), tbl[i].xo, tbl[i].xt, tbl[i].xc);
    end

    do_reset();
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] xo;
      drive(1, 1, 0, 0, 4'd0);
      xo = e < 3 ? 4'd0 : e < 6 ? WRAP_DN : (SAT ? 4'd0 : 4'd8);
      chk3($sformatf("down%0d", e), xo, e % 3 == 0, e == 3 || (SAT && e == 6));
    end

    do_reset();
    for (int e = 1; e <= 36; e++) begin
      logic [3:0] xo;
      drive(1, 1, 1, 0, 4'd0);
      xo = SAT ? 4'(e / 3 > 9 ? 9 : e / 3) : 4'((e / 3) % 10);
      chk3($sformatf("up%0d", e), xo, e % 3 == 0, SAT ? (e % 3 == 0 && e >= 30) : e == 30);
      if (e <= 9) begin
        chk($sformatf("p1 out%0d", e), 16'(out1), 16'(e));
        chk($sformatf("p1 tick%0d", e), 16'(tick1), 16'd1);
      end
    end

    drive(1, 1, 1, 1, 4'd6);
    chk3("ld6", 4'd6, 1'b0, 1'b0);
    drive(1, 1, 1, 0, 4'd0);
    drive(1, 1, 1, 0, 4'd0);
    drive(1, 1, 1, 0, 4'd0);
    chk3("to7", 4'd7, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk3("arst pulse", 4'd0, 1'b0, 1'b0);
    chk("arst p1 out", 16'(out1), 16'd0);
    drive(1, 1, 1, 0, 4'd0);
    chk3("rel a1", 4'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk3("arst mid", 4'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      drive(1, 1, 1, 0, 4'd0);
      chk3($sformatf("rel b%0d", e), e == 3 ? 4'd1 : 4'd0, e == 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
